// File: rtl/pll_rst_sequencer.sv
// PLL reset/lock supervisor and ordered downstream reset release for the DSP TX chain.
// Runs on the free-running reference clock; pll_lock is resynchronised before use.
module pll_rst_sequencer #(
  parameter int NSTAGES        = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int SETTLE         = 256,
  parameter int STAGE_GAP      = 16,
  parameter int RETRY_W        = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  output logic               pll_resetb,
  output logic [NSTAGES-1:0] stage_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               fail
);

  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (SETTLE > STAGE_GAP) ? SETTLE : STAGE_GAP;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C) + 1;
  localparam int IDX_W = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NSTAGES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_SETTLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             sync_p0;
  logic             lock_s;
  logic             lose;

  function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Lock is only treated as "lost" once the downstream chain has started to come out of reset.
  assign lose = !lock_s && (state == S_RELEASE || state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PLL_RST;
      cnt        <= '0;
      idx        <= '0;
      sync_p0    <= 1'b0;
      lock_s     <= 1'b0;
      pll_resetb <= 1'b0;
      stage_rst  <= '1;
      ready      <= 1'b0;
      lock_lost  <= 1'b0;
      retry_cnt  <= '0;
      fail       <= 1'b0;
    end else begin
      sync_p0   <= pll_lock;
      lock_s    <= sync_p0;
      lock_lost <= 1'b0;
      if (lose) begin
        state      <= S_PLL_RST;
        cnt        <= '0;
        idx        <= '0;
        pll_resetb <= 1'b0;
        stage_rst  <= '1;
        ready      <= 1'b0;
        lock_lost  <= 1'b1;
      end else begin
        case (state)
          S_PLL_RST: begin
            stage_rst <= '1;
            ready     <= 1'b0;
            if (cnt == RST_LAST) begin
              state      <= S_WAIT_LOCK;
              cnt        <= '0;
              pll_resetb <= 1'b1;
            end else begin
              cnt        <= cnt + 1'b1;
              pll_resetb <= 1'b0;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state <= S_SETTLE;
              cnt   <= '0;
            end else if (cnt == TO_LAST) begin
              state      <= S_PLL_RST;
              cnt        <= '0;
              pll_resetb <= 1'b0;
              retry_cnt  <= sat_inc(retry_cnt);
              if (retry_cnt == '1) fail <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SETTLE: begin
            if (!lock_s) begin
              state      <= S_PLL_RST;
              cnt        <= '0;
              pll_resetb <= 1'b0;
            end else if (cnt == SETTLE_LAST) begin
              state <= S_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (cnt == GAP_LAST) begin
              stage_rst[idx] <= 1'b0;
              cnt            <= '0;
              if (idx == IDX_LAST) begin
                state <= S_RUN;
                ready <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            ready      <= 1'b1;
            stage_rst  <= '0;
            pll_resetb <= 1'b1;
          end
          default: begin
            state <= S_PLL_RST;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_rst_sequencer.sv
// Directed bench for pll_rst_sequencer: default instance plus a RETRY_W=2 instance for saturation/fail.
module tb_pll_rst_sequencer;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, lock_a = 1'b1;
  logic       resetb_a, ready_a, lost_a, fail_a;
  logic [2:0] srst_a;
  logic [3:0] retry_a;
  logic       rst_b = 1'b1, lock_b = 1'b0;
  logic       resetb_b, ready_b, lost_b, fail_b;
  logic [2:0] srst_b;
  logic [1:0] retry_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pll_rst_sequencer dut_a (
    .clk(clk), .rst(rst_a), .pll_lock(lock_a), .pll_resetb(resetb_a), .stage_rst(srst_a),
    .ready(ready_a), .lock_lost(lost_a), .retry_cnt(retry_a), .fail(fail_a)
  );

  pll_rst_sequencer #(.RETRY_W(2)) dut_b (
    .clk(clk), .rst(rst_b), .pll_lock(lock_b), .pll_resetb(resetb_b), .stage_rst(srst_b),
    .ready(ready_b), .lock_lost(lost_b), .retry_cnt(retry_b), .fail(fail_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset values, then lock tied high: resetb at +16, stages at +289/+305/+321.
  task automatic test_power_up();
    rst_a = 1'b1; lock_a = 1'b1;
    step(1);
    total++; if (resetb_a !== 1'b0) begin bad++; $display("FAIL rst_resetb act=%b exp=0", resetb_a); end
    total++; if (srst_a !== 3'b111) begin bad++; $display("FAIL rst_stage act=%b exp=111", srst_a); end
    total++; if ({ready_a, lost_a, fail_a} !== 3'b000) begin bad++; $display("FAIL rst_flags act=%b exp=000", {ready_a, lost_a, fail_a}); end
    total++; if (retry_a !== 4'd0) begin bad++; $display("FAIL rst_retry act=%0d exp=0", retry_a); end
    rst_a = 1'b0;
    step(15);
    total++; if (resetb_a !== 1'b0) begin bad++; $display("FAIL pu_resetb15 act=%b exp=0", resetb_a); end
    step(1);
    total++; if (resetb_a !== 1'b1) begin bad++; $display("FAIL pu_resetb16 act=%b exp=1", resetb_a); end
    step(272);
    total++; if (srst_a !== 3'b111) begin bad++; $display("FAIL pu_stage288 act=%b exp=111", srst_a); end
    step(1);
    total++; if (srst_a !== 3'b110) begin bad++; $display("FAIL pu_stage289 act=%b exp=110", srst_a); end
    step(15);
    total++; if (srst_a !== 3'b110) begin bad++; $display("FAIL pu_stage304 act=%b exp=110", srst_a); end
    step(1);
    total++; if (srst_a !== 3'b100) begin bad++; $display("FAIL pu_stage305 act=%b exp=100", srst_a); end
    step(15);
    total++; if ({srst_a, ready_a} !== 4'b1000) begin bad++; $display("FAIL pu_stage320 act=%b exp=1000", {srst_a, ready_a}); end
    step(1);
    total++; if ({srst_a, ready_a} !== 4'b0001) begin bad++; $display("FAIL pu_ready321 act=%b exp=0001", {srst_a, ready_a}); end
    total++; if ({retry_a, fail_a} !== 5'b00000) begin bad++; $display("FAIL pu_retry act=%b exp=00000", {retry_a, fail_a}); end
  endtask

  // One-cycle lock drop in RUN: reaction on the 3rd edge after the drop, then full re-sequence.
  task automatic test_lock_loss(input logic [3:0] exp_retry);
    lock_a = 1'b0;
    step(1);
    lock_a = 1'b1;
    step(1);
    total++; if ({lost_a, ready_a} !== 2'b01) begin bad++; $display("FAIL ll_before act=%b exp=01", {lost_a, ready_a}); end
    step(1);
    total++; if (lost_a !== 1'b1) begin bad++; $display("FAIL ll_pulse act=%b exp=1", lost_a); end
    total++; if ({srst_a, ready_a, resetb_a} !== 5'b11100) begin bad++; $display("FAIL ll_same_edge act=%b exp=11100", {srst_a, ready_a, resetb_a}); end
    step(1);
    total++; if (lost_a !== 1'b0) begin bad++; $display("FAIL ll_one_cycle act=%b exp=0", lost_a); end
    step(14);
    total++; if (resetb_a !== 1'b0) begin bad++; $display("FAIL ll_resetb15 act=%b exp=0", resetb_a); end
    step(1);
    total++; if (resetb_a !== 1'b1) begin bad++; $display("FAIL ll_resetb16 act=%b exp=1", resetb_a); end
    step(304);
    total++; if ({srst_a, ready_a} !== 4'b1000) begin bad++; $display("FAIL ll_resq_pre act=%b exp=1000", {srst_a, ready_a}); end
    step(1);
    total++; if ({srst_a, ready_a} !== 4'b0001) begin bad++; $display("FAIL ll_resq_done act=%b exp=0001", {srst_a, ready_a}); end
    total++; if (retry_a !== exp_retry) begin bad++; $display("FAIL ll_retry act=%0d exp=%0d", retry_a, exp_retry); end
  endtask

  // Lock drop at SETTLE count 100: back to PLL_RST, settle restarts so stage 0 lands at 120+289.
  task automatic test_settle_drop();
    rst_a = 1'b1; lock_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    step(117);
    lock_a = 1'b0;
    step(1);
    lock_a = 1'b1;
    step(1);
    total++; if (resetb_a !== 1'b1) begin bad++; $display("FAIL sd_resetb119 act=%b exp=1", resetb_a); end
    step(1);
    total++; if ({resetb_a, srst_a, lost_a} !== 5'b01110) begin bad++; $display("FAIL sd_back_rst act=%b exp=01110", {resetb_a, srst_a, lost_a}); end
    step(288);
    total++; if ({srst_a, resetb_a} !== 4'b1111) begin bad++; $display("FAIL sd_stage408 act=%b exp=1111", {srst_a, resetb_a}); end
    step(1);
    total++; if (srst_a !== 3'b110) begin bad++; $display("FAIL sd_stage409 act=%b exp=110", srst_a); end
  endtask

  // Three lock timeouts, then lock: retry_cnt=3, fail stays 0, normal release follows.
  task automatic test_timeouts();
    rst_a = 1'b1; lock_a = 1'b0;
    step(1);
    rst_a = 1'b0;
    for (int r = 0; r < 3; r++) begin
      step(15);
      total++; if (resetb_a !== 1'b0) begin bad++; $display("FAIL to%0d_low act=%b exp=0", r, resetb_a); end
      step(1);
      total++; if (resetb_a !== 1'b1) begin bad++; $display("FAIL to%0d_high act=%b exp=1", r, resetb_a); end
      step(4095);
      total++; if ({resetb_a, retry_a} !== {1'b1, 4'(r)}) begin bad++; $display("FAIL to%0d_pre act=%b exp=%b", r, {resetb_a, retry_a}, {1'b1, 4'(r)}); end
      step(1);
      total++; if ({resetb_a, retry_a, fail_a} !== {1'b0, 4'(r + 1), 1'b0}) begin bad++; $display("FAIL to%0d_hit act=%b exp=%b", r, {resetb_a, retry_a, fail_a}, {1'b0, 4'(r + 1), 1'b0}); end
    end
    step(16);
    total++; if (resetb_a !== 1'b1) begin bad++; $display("FAIL to_final_wait act=%b exp=1", resetb_a); end
    lock_a = 1'b1;
    step(306);
    total++; if ({srst_a, ready_a} !== 4'b1000) begin bad++; $display("FAIL to_rel_pre act=%b exp=1000", {srst_a, ready_a}); end
    step(1);
    total++; if ({srst_a, ready_a} !== 4'b0001) begin bad++; $display("FAIL to_rel_done act=%b exp=0001", {srst_a, ready_a}); end
    total++; if ({retry_a, fail_a} !== 5'b00110) begin bad++; $display("FAIL to_retry act=%b exp=00110", {retry_a, fail_a}); end
  endtask

  // From RUN with retry=3: lose lock, then rst one cycle after stage 0 releases.
  task automatic test_rst_mid_release();
    lock_a = 1'b0;
    step(1);
    lock_a = 1'b1;
    step(2);
    step(289);
    total++; if ({srst_a, ready_a, retry_a} !== 8'b11000011) begin bad++; $display("FAIL mr_stage0 act=%b exp=11000011", {srst_a, ready_a, retry_a}); end
    rst_a = 1'b1;
    step(1);
    rst_a = 1'b0;
    total++; if ({srst_a, ready_a, resetb_a} !== 5'b11100) begin bad++; $display("FAIL mr_outs act=%b exp=11100", {srst_a, ready_a, resetb_a}); end
    total++; if ({retry_a, fail_a, lost_a} !== 6'b000000) begin bad++; $display("FAIL mr_cnts act=%b exp=000000", {retry_a, fail_a, lost_a}); end
    step(1);
    total++; if ({srst_a, resetb_a} !== 4'b1110) begin bad++; $display("FAIL mr_after act=%b exp=1110", {srst_a, resetb_a}); end
  endtask

  // RETRY_W=2, lock stuck low: retry saturates at 3, fail sets on the 4th timeout and sticks.
  task automatic test_fail_saturate();
    logic [1:0] exp_retry;
    logic       exp_fail_pre;
    logic       exp_fail;
    rst_b = 1'b1; lock_b = 1'b0;
    step(1);
    rst_b = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      exp_retry    = (t > 3) ? 2'd3 : 2'(t);
      exp_fail_pre = (t >= 5);
      exp_fail     = (t >= 4);
      step(16 + 4095);
      total++; if ({resetb_b, fail_b} !== {1'b1, exp_fail_pre}) begin bad++; $display("FAIL fs%0d_pre act=%b exp=%b", t, {resetb_b, fail_b}, {1'b1, exp_fail_pre}); end
      step(1);
      total++; if ({resetb_b, retry_b, fail_b} !== {1'b0, exp_retry, exp_fail}) begin bad++; $display("FAIL fs%0d_hit act=%b exp=%b", t, {resetb_b, retry_b, fail_b}, {1'b0, exp_retry, exp_fail}); end
    end
  endtask

  initial begin
    test_power_up();
    test_lock_loss(4'd0);
    test_settle_drop();
    test_timeouts();
    test_lock_loss(4'd3);
    test_rst_mid_release();
    test_fail_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
